// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared default sizing constants for the modport FIFO slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
endpackage

`default_nettype wire

// File: rtl/modport_fifo_if.sv
// ============================================================================
// Module : modport_fifo_if
// Brief  : FIFO access bus; the master drives requests, the FIFO is the slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface modport_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic                  Wr_enable;
  logic                  Read_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport master (
    output Wr_enable,
    output Read_enable,
    output data_in,
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  Wr_enable,
    input  Read_enable,
    input  data_in,
    output data_out,
    output full,
    output empty
  );
endinterface

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================================
// Module : fifo_mem
// Brief  : Simple dual-port RAM, synchronous write and registered read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_wr_en,
  input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  wire logic [DATA_WIDTH-1:0] i_wr_data,
  input  wire logic                  i_rd_en,
  input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic      [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Same-address read/write returns the old word (needed when full).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/modport_fifo.sv
// ============================================================================
// Module : modport_fifo
// Brief  : Synchronous FIFO with pointer/flag control and a modport bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module modport_fifo
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int fifo_size  = 2 ** ADDR_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          reset,
  modport_fifo_if.slave      bus
);

  localparam logic [ADDR_WIDTH:0] c_ptr_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_rd_acc;
  logic                w_wr_acc;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign w_rd_acc = !reset && bus.Read_enable && !w_empty;
  assign w_wr_acc = !reset && bus.Wr_enable && (!w_full || w_rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (fifo_size)
  ) u_mem (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wr_data (bus.data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (bus.data_out)
  );

  assign bus.empty = w_empty;
  assign bus.full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_modport_fifo.sv
// ============================================================================
// Module : tb_modport_fifo
// Brief  : Scoreboard bench for modport_fifo with directed vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_modport_fifo;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  bit   done = 1'b0;

  logic [DW-1:0] exp_q[$];    // expected data_out per accepted read
  logic [DW-1:0] model_q[$];  // words currently stored
  logic [DW-1:0] last_out = '0;

  modport_fifo_if #(.DATA_WIDTH(DW)) bus ();

  modport_fifo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .fifo_size  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: an accepted read presents a word one edge later; otherwise data_out holds.
  always @(posedge clk) begin
    logic acc;
    logic rs;
    rs  = reset;
    acc = !reset && bus.Read_enable && !bus.empty;
    #1;
    if (rs) begin
      last_out = '0;
      check("reset_data_out", {24'd0, bus.data_out}, 32'h0);
    end else if (acc) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", {24'd0, bus.data_out}, 32'hDEAD);
      end else begin
        last_out = exp_q.pop_front();
        check("read_data", {24'd0, bus.data_out}, {24'd0, last_out});
      end
    end else begin
      check("hold_data_out", {24'd0, bus.data_out}, {24'd0, last_out});
    end
  end

  // Drive one cycle; the bench model decides acceptance and expected flags.
  task automatic cyc(input logic we, input logic re, input logic [DW-1:0] din);
    logic rd_ok;
    logic wr_ok;
    @(negedge clk);
    bus.Wr_enable   = we;
    bus.Read_enable = re;
    bus.data_in     = din;
    rd_ok = re && (model_q.size() > 0);
    wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(din);
    @(posedge clk);
    #2;
    check("empty", {31'd0, bus.empty}, {31'd0, model_q.size() == 0});
    check("full",  {31'd0, bus.full},  {31'd0, model_q.size() == DEPTH});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bus.Wr_enable   = 1'b1;
    bus.Read_enable = 1'b1;
    bus.data_in     = 8'hEE;
    model_q.delete();
    exp_q.delete();
    repeat (n) @(posedge clk);
    #2;
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full",  {31'd0, bus.full},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.Wr_enable   = 1'b0;
    bus.Read_enable = 1'b0;
  endtask

  initial begin
    bus.Wr_enable   = 1'b0;
    bus.Read_enable = 1'b0;
    bus.data_in     = '0;
    do_reset(2);

    // Idle after reset.
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check("idle_data_out", {24'd0, bus.data_out}, 32'h0);

    // Basic ordering.
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    repeat (3) cyc(1'b0, 1'b1, 8'h00);
    check("empty_after_3", {31'd0, bus.empty}, 32'd1);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'(i));
    check("full_after_32", {31'd0, bus.full}, 32'd1);
    cyc(1'b1, 1'b0, 8'hFF);
    repeat (DEPTH) cyc(1'b0, 1'b1, 8'h00);
    check("last_drained", {24'd0, bus.data_out}, 32'h1F);

    // Read on empty holds data_out.
    repeat (2) cyc(1'b0, 1'b1, 8'h00);
    check("empty_read_hold", {24'd0, bus.data_out}, 32'h1F);

    // 31 stored, fill to full, then simultaneous read+write while full.
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 1'b0, DW'(8'h40 + i));
    check("not_full_31", {31'd0, bus.full}, 32'd0);
    cyc(1'b1, 1'b0, 8'h5F);
    cyc(1'b1, 1'b1, 8'hAA);
    check("full_after_rw", {31'd0, bus.full}, 32'd1);
    check("oldest_out", {24'd0, bus.data_out}, 32'h40);
    cyc(1'b1, 1'b1, 8'hAB);
    repeat (DEPTH) cyc(1'b0, 1'b1, 8'h00);
    check("wrap_last", {24'd0, bus.data_out}, 32'hAB);

    // Simultaneous read+write on empty: only the write proceeds.
    cyc(1'b1, 1'b1, 8'h77);
    check("rw_on_empty", {31'd0, bus.empty}, 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    check("rw_on_empty_data", {24'd0, bus.data_out}, 32'h77);

    // Reset mid-operation discards stored words.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(8'hC0 + i));
    do_reset(1);
    check("midrst_data_out", {24'd0, bus.data_out}, 32'h0);
    cyc(1'b0, 1'b1, 8'h00);
    check("midrst_read_none", {24'd0, bus.data_out}, 32'h0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule

`default_nettype wire
